// File: rtl/audio_pkg.sv
// Shared types and constants for the audio record/playback sample store.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package audio_pkg;

   localparam int SAMPLE_W = 16;

   // Encoding is visible on state_o, so the values are pinned explicitly.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RECORD     = 2'd1,
      PLAY_FETCH = 2'd2,
      PLAY_HOLD  = 2'd3
   } buf_state_t;

endpackage

// File: rtl/sample_ram_sp.sv
// Single-port synchronous sample RAM, DEPTH x DATA_W, no reset (maps to block RAM).
// Latency: write lands at the clock edge; read data appears 1 cycle after re_i.
// Backpressure: none; rdata_o holds its last read value while re_i is low.
// Ports: clock_i; we_i/re_i (write has priority); addr_i; wdata_i; rdata_o.
module sample_ram_sp
   import audio_pkg::*;
#(
   parameter  int DATA_W = SAMPLE_W,
   parameter  int DEPTH  = 4096,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end else if (re_i) begin
         rdata_o <= mem[addr_i];
      end
   end

endmodule

// File: rtl/audio_record_buffer.sv
// Record/playback sample store: captures deserializer words, replays them in order.
// Latency: write counted at the wr_valid_i edge; first playback word valid 2 edges after play rise.
// Backpressure: rd_valid_o/rd_data_o hold until rd_ready_i; 1 word per 2 cycles sustained; no input backpressure (overflow words dropped with drop_o).
// Ports: clock_i, reset_n_i (async, active-low); record_i/play_i requests (rise starts, low stops);
//        wr_valid_i/wr_data_i capture input; rd_valid_o/rd_ready_i/rd_data_o playback handshake;
//        length_o/full_o fill status; drop_o/done_o single-cycle pulses; state_o FSM state.
module audio_record_buffer
   import audio_pkg::*;
#(
   parameter  int DATA_W = SAMPLE_W,
   parameter  int DEPTH  = 4096,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              record_i,
   input  logic              play_i,
   input  logic              wr_valid_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_ready_i,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [ADDR_W:0]   length_o,
   output logic              full_o,
   output logic              drop_o,
   output logic              done_o,
   output logic [1:0]        state_o
);

   localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   buf_state_t        state_q, state_d;
   logic              record_q, play_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   length_q;
   logic              drop_q, done_q;
   logic              rd_loaded_q;
   logic [DATA_W-1:0] ram_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              record_rise, play_rise;
   logic              full, last_word, transfer;
   logic              wr_accept, wr_drop, ram_re;

   assign record_rise = record_i & ~record_q;
   assign play_rise   = play_i & ~play_q;
   assign full        = (length_q == LEN_FULL);
   assign last_word   = (({1'b0, rd_ptr_q} + LEN_ONE) == length_q);
   // A low play_i aborts, so it also vetoes a handshake in the same cycle.
   assign transfer    = (state_q == PLAY_HOLD) && play_i && rd_ready_i;
   // Once in RECORD, a word arriving with the stop cycle is still stored.
   assign wr_accept   = (state_q == RECORD) && wr_valid_i && !full;
   assign wr_drop     = (state_q == RECORD) && wr_valid_i && full;
   // Reading is gated by play_i so an abort in FETCH leaves rd_data_o untouched.
   assign ram_re      = (state_q == PLAY_FETCH) && play_i;
   // length doubles as the write pointer: it never exceeds DEPTH-1 when a write is accepted.
   assign ram_addr    = (state_q == RECORD) ? length_q[ADDR_W-1:0] : rd_ptr_q;

   sample_ram_sp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clock_i (clock_i),
      .we_i    (wr_accept),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (wr_data_i),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (record_rise) begin
               state_d = RECORD;
            end else if (play_rise && (length_q != '0)) begin
               state_d = PLAY_FETCH;
            end
         end
         RECORD: begin
            if (!record_i) begin
               state_d = IDLE;
            end
         end
         PLAY_FETCH: begin
            state_d = play_i ? PLAY_HOLD : IDLE;
         end
         PLAY_HOLD: begin
            if (!play_i) begin
               state_d = IDLE;
            end else if (rd_ready_i) begin
               state_d = last_word ? IDLE : PLAY_FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         record_q    <= 1'b0;
         play_q      <= 1'b0;
         rd_ptr_q    <= '0;
         length_q    <= '0;
         drop_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         record_q <= record_i;
         play_q   <= play_i;
         drop_q   <= wr_drop;
         done_q   <= transfer && last_word;

         if ((state_q == IDLE) && record_rise) begin
            length_q <= '0;
         end else if (wr_accept) begin
            length_q <= length_q + LEN_ONE;
         end

         if ((state_q == IDLE) && (state_d == PLAY_FETCH)) begin
            rd_ptr_q <= '0;
         end else if (transfer && !last_word) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end

         if (ram_re) begin
            rd_loaded_q <= 1'b1;
         end
      end
   end

   // The RAM output register has no reset; mask it until the first read after reset.
   assign rd_data_o  = rd_loaded_q ? ram_rdata : '0;
   assign rd_valid_o = (state_q == PLAY_HOLD);
   assign length_o   = length_q;
   assign full_o     = full;
   assign drop_o     = drop_q;
   assign done_o     = done_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_audio_record_buffer.sv
module tb_audio_record_buffer;

   localparam int DA = 4096;
   localparam int DB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic record = 1'b0, play = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
   logic [15:0] wr_data = '0;

   logic        a_vld, b_vld, a_full, b_full, a_drop, b_drop, a_done, b_done;
   logic [15:0] a_dat, b_dat;
   logic [12:0] a_len;
   logic [3:0]  b_len;
   logic [1:0]  a_state, b_state;

   int checks = 0;
   int errors = 0;
   int a_drops = 0, b_drops = 0, a_dones = 0, b_dones = 0;

   // Reference model: words offered during the most recent recording session.
   logic [15:0] model_q[$];
   logic [15:0] got_a[$];
   logic [15:0] got_b[$];
   int          t_a[$];
   logic        to_flag, end_done, ab_vld, hold_ok;
   logic [1:0]  first_state, ab_state;
   logic [15:0] hold_dat;

   always #5 clk = ~clk;

   audio_record_buffer #(.DATA_W(16), .DEPTH(DA)) dut_a (
      .clock_i(clk), .reset_n_i(rst_n), .record_i(record), .play_i(play),
      .wr_valid_i(wr_valid), .wr_data_i(wr_data), .rd_ready_i(rd_ready),
      .rd_valid_o(a_vld), .rd_data_o(a_dat), .length_o(a_len), .full_o(a_full),
      .drop_o(a_drop), .done_o(a_done), .state_o(a_state));

   audio_record_buffer #(.DATA_W(16), .DEPTH(DB)) dut_b (
      .clock_i(clk), .reset_n_i(rst_n), .record_i(record), .play_i(play),
      .wr_valid_i(wr_valid), .wr_data_i(wr_data), .rd_ready_i(rd_ready),
      .rd_valid_o(b_vld), .rd_data_o(b_dat), .length_o(b_len), .full_o(b_full),
      .drop_o(b_drop), .done_o(b_done), .state_o(b_state));

   always @(negedge clk) begin
      if (a_drop) a_drops++;
      if (b_drop) b_drops++;
      if (a_done) a_dones++;
      if (b_done) b_dones++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Record every word of model_q, one wr_valid pulse per 'gap' cycles.
   task automatic do_record(input int gap, input bit stop_with_last);
      record = 1'b0; wr_valid = 1'b0; @(negedge clk);
      record = 1'b1; @(negedge clk);
      for (int i = 0; i < model_q.size(); i++) begin
         wr_valid = 1'b1; wr_data = model_q[i];
         if (stop_with_last && (i == model_q.size() - 1)) record = 1'b0;
         @(negedge clk);
         wr_valid = 1'b0;
         for (int g = 1; g < gap; g++) @(negedge clk);
      end
      record = 1'b0; @(negedge clk); @(negedge clk);
   endtask

   // mode 0: ready always 1; 1: random ready; 2: ready low 10 cycles on word 1.
   task automatic do_play(input int mode, input int abort_at);
      int n;
      int hold_cnt;
      got_a.delete(); got_b.delete(); t_a.delete();
      to_flag = 1'b0; end_done = 1'b0; hold_ok = 1'b1; hold_cnt = 0;
      ab_state = 2'd3; ab_vld = 1'b1;
      play = 1'b0; rd_ready = 1'b0; @(negedge clk);
      play = 1'b1; @(negedge clk);
      first_state = a_state;
      n = 0;
      while (1) begin
         if (a_state == 2'd0 && b_state == 2'd0) begin
            end_done = a_done;
            break;
         end
         if (n >= 2000) begin
            to_flag = 1'b1;
            break;
         end
         case (mode)
            0: rd_ready = 1'b1;
            1: rd_ready = ($urandom_range(0, 2) != 0);
            default: begin
               if (a_vld && got_a.size() == 1 && hold_cnt < 10) begin
                  if (hold_cnt == 0) hold_dat = a_dat;
                  else if (a_dat !== hold_dat) hold_ok = 1'b0;
                  hold_cnt++;
                  rd_ready = 1'b0;
               end else begin
                  rd_ready = 1'b1;
               end
            end
         endcase
         if (abort_at >= 0 && a_vld && got_a.size() == abort_at) begin
            play = 1'b0; rd_ready = 1'b1;
            @(negedge clk);
            ab_state = a_state; ab_vld = a_vld;
            break;
         end
         if (a_vld && rd_ready) begin
            got_a.push_back(a_dat);
            t_a.push_back(n);
         end
         if (b_vld && rd_ready) got_b.push_back(b_dat);
         @(negedge clk);
         n++;
      end
      if (hold_cnt != 0 && hold_cnt != 10) hold_ok = 1'b0;
      play = 1'b0; rd_ready = 1'b0; @(negedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (a_state !== 2'd0 || a_vld !== 1'b0 || a_dat !== 16'h0) begin
         errors++; $display("FAIL reset_a_ctl: state=%0d vld=%0b dat=%h want 0 0 0000", a_state, a_vld, a_dat);
      end
      checks++; if (a_len !== 13'd0 || a_full !== 1'b0 || a_drop !== 1'b0 || a_done !== 1'b0) begin
         errors++; $display("FAIL reset_a_stat: len=%0d full=%0b drop=%0b done=%0b want 0", a_len, a_full, a_drop, a_done);
      end
      checks++; if (b_state !== 2'd0 || b_vld !== 1'b0 || b_len !== 4'd0 || b_dat !== 16'h0) begin
         errors++; $display("FAIL reset_b: state=%0d vld=%0b len=%0d dat=%h want 0", b_state, b_vld, b_len, b_dat);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_record();
      int d0;
      d0 = a_drops;
      model_q = '{16'h0F0F, 16'hF0F0, 16'h1234, 16'hABCD};
      record = 1'b1; @(negedge clk);
      checks++; if (a_state !== 2'd1) begin
         errors++; $display("FAIL rec_enter: state=%0d want 1", a_state);
      end
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = model_q[i];
         @(negedge clk);
         wr_valid = 1'b0;
         checks++; if (a_len !== 13'(i + 1)) begin
            errors++; $display("FAIL rec_len_step%0d: len=%0d want %0d", i, a_len, i + 1);
         end
         repeat (31) @(negedge clk);
      end
      record = 1'b0; @(negedge clk); @(negedge clk);
      checks++; if (a_len !== 13'd4 || a_state !== 2'd0) begin
         errors++; $display("FAIL rec_final: len=%0d state=%0d want 4 0", a_len, a_state);
      end
      checks++; if (a_drops != d0) begin
         errors++; $display("FAIL rec_drop: drops=%0d want 0", a_drops - d0);
      end
   endtask

   task automatic test_play();
      int d0;
      d0 = a_dones;
      do_play(0, -1);
      checks++; if (to_flag !== 1'b0) begin
         errors++; $display("FAIL play_timeout: timed out");
      end
      checks++; if (first_state !== 2'd2) begin
         errors++; $display("FAIL play_first_state: state=%0d want 2", first_state);
      end
      checks++; if (t_a.size() == 0 || t_a[0] != 1) begin
         errors++; $display("FAIL play_latency: first transfer at %0d want 1", t_a.size() ? t_a[0] : -1);
      end
      checks++; if (got_a.size() != model_q.size()) begin
         errors++; $display("FAIL play_count: got %0d want %0d", got_a.size(), model_q.size());
      end
      for (int i = 0; i < got_a.size() && i < model_q.size(); i++) begin
         checks++; if (got_a[i] !== model_q[i]) begin
            errors++; $display("FAIL play_word%0d: got %h want %h", i, got_a[i], model_q[i]);
         end
      end
      for (int i = 1; i < t_a.size(); i++) begin
         checks++; if (t_a[i] - t_a[i-1] != 2) begin
            errors++; $display("FAIL play_rate%0d: spacing %0d want 2", i, t_a[i] - t_a[i-1]);
         end
      end
      checks++; if (a_dones - d0 != 1 || end_done !== 1'b1) begin
         errors++; $display("FAIL play_done: pulses=%0d at_end=%0b want 1 1", a_dones - d0, end_done);
      end
      checks++; if (a_state !== 2'd0 || a_vld !== 1'b0) begin
         errors++; $display("FAIL play_idle: state=%0d vld=%0b want 0 0", a_state, a_vld);
      end
   endtask

   task automatic test_backpressure();
      do_play(2, -1);
      checks++; if (hold_ok !== 1'b1 || hold_dat !== model_q[1]) begin
         errors++; $display("FAIL bp_hold: stable=%0b dat=%h want 1 %h", hold_ok, hold_dat, model_q[1]);
      end
      checks++; if (got_a.size() != model_q.size() || to_flag) begin
         errors++; $display("FAIL bp_count: got %0d want %0d", got_a.size(), model_q.size());
      end
      for (int i = 0; i < got_a.size() && i < model_q.size(); i++) begin
         checks++; if (got_a[i] !== model_q[i]) begin
            errors++; $display("FAIL bp_word%0d: got %h want %h", i, got_a[i], model_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      int da, db;
      da = a_drops; db = b_drops;
      model_q.delete();
      for (int i = 0; i < 10; i++) model_q.push_back(16'($urandom));
      do_record(2, 1'b0);
      checks++; if (b_len !== 4'(DB) || b_full !== 1'b1) begin
         errors++; $display("FAIL ovf_b_len: len=%0d full=%0b want 8 1", b_len, b_full);
      end
      checks++; if (b_drops - db != 2) begin
         errors++; $display("FAIL ovf_b_drops: got %0d want 2", b_drops - db);
      end
      checks++; if (a_len !== 13'd10 || a_full !== 1'b0 || a_drops != da) begin
         errors++; $display("FAIL ovf_a: len=%0d full=%0b drops=%0d want 10 0 0", a_len, a_full, a_drops - da);
      end
      do_play(1, -1);
      checks++; if (got_b.size() != DB || got_a.size() != 10 || to_flag) begin
         errors++; $display("FAIL ovf_play_count: b=%0d a=%0d want 8 10", got_b.size(), got_a.size());
      end
      for (int i = 0; i < got_b.size() && i < DB; i++) begin
         checks++; if (got_b[i] !== model_q[i]) begin
            errors++; $display("FAIL ovf_b_word%0d: got %h want %h", i, got_b[i], model_q[i]);
         end
      end
   endtask

   task automatic test_abort();
      int d0;
      model_q.delete();
      for (int i = 0; i < 5; i++) model_q.push_back(16'($urandom));
      do_record(1, 1'b0);
      d0 = a_dones;
      do_play(0, 2);
      checks++; if (ab_state !== 2'd0 || ab_vld !== 1'b0) begin
         errors++; $display("FAIL abort_idle: state=%0d vld=%0b want 0 0", ab_state, ab_vld);
      end
      checks++; if (a_dones != d0 || got_a.size() != 2) begin
         errors++; $display("FAIL abort_done: dones=%0d words=%0d want 0 2", a_dones - d0, got_a.size());
      end
      do_play(0, -1);
      checks++; if (got_a.size() != 5 || a_dones - d0 != 1 || to_flag) begin
         errors++; $display("FAIL abort_replay: words=%0d dones=%0d want 5 1", got_a.size(), a_dones - d0);
      end
      for (int i = 0; i < got_a.size() && i < 5; i++) begin
         checks++; if (got_a[i] !== model_q[i]) begin
            errors++; $display("FAIL abort_word%0d: got %h want %h", i, got_a[i], model_q[i]);
         end
      end
   endtask

   task automatic test_boundary();
      int d0;
      // Empty store: play rise is ignored.
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
      d0 = a_dones;
      do_play(0, -1);
      checks++; if (first_state !== 2'd0 || a_dones != d0 || got_a.size() != 0) begin
         errors++; $display("FAIL empty_play: state=%0d dones=%0d want 0 0", first_state, a_dones - d0);
      end
      // Simultaneous rises: record wins; held play is not remembered.
      record = 1'b1; play = 1'b1; @(negedge clk);
      checks++; if (a_state !== 2'd1) begin
         errors++; $display("FAIL both_rise: state=%0d want 1", a_state);
      end
      wr_valid = 1'b1; wr_data = 16'h5A5A; record = 1'b0; @(negedge clk);
      wr_valid = 1'b0; @(negedge clk);
      checks++; if (a_state !== 2'd0 || a_len !== 13'd1) begin
         errors++; $display("FAIL stop_write: state=%0d len=%0d want 0 1", a_state, a_len);
      end
      play = 1'b0; @(negedge clk);
      // Asynchronous reset in the middle of recording.
      record = 1'b1; @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = 16'($urandom); @(negedge clk);
      end
      wr_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_len !== 13'd0 || a_state !== 2'd0 || b_len !== 4'd0) begin
         errors++; $display("FAIL async_reset: a_len=%0d a_state=%0d b_len=%0d want 0", a_len, a_state, b_len);
      end
      record = 1'b0;
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
   endtask

   task automatic test_random();
      int n, da, db, ea, eb, exp_b;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(0, 12);
         model_q.delete();
         for (int i = 0; i < n; i++) model_q.push_back(16'($urandom));
         da = a_drops; db = b_drops;
         do_record($urandom_range(1, 3), 1'($urandom_range(0, 1)));
         exp_b = (n > DB) ? DB : n;
         checks++; if (a_len !== 13'(n) || b_len !== 4'(exp_b)) begin
            errors++; $display("FAIL rnd%0d_len: a=%0d b=%0d want %0d %0d", it, a_len, b_len, n, exp_b);
         end
         checks++; if (b_drops - db != n - exp_b || a_drops != da || b_full !== (n >= DB)) begin
            errors++; $display("FAIL rnd%0d_drop: b=%0d a=%0d full=%0b want %0d 0", it, b_drops - db, a_drops - da, b_full, n - exp_b);
         end
         ea = a_dones; eb = b_dones;
         do_play(1, -1);
         checks++; if (to_flag || got_a.size() != n || got_b.size() != exp_b) begin
            errors++; $display("FAIL rnd%0d_count: a=%0d b=%0d want %0d %0d", it, got_a.size(), got_b.size(), n, exp_b);
         end
         checks++; if (a_dones - ea != (n > 0) || b_dones - eb != (n > 0)) begin
            errors++; $display("FAIL rnd%0d_done: a=%0d b=%0d want %0d", it, a_dones - ea, b_dones - eb, n > 0);
         end
         for (int i = 0; i < got_a.size() && i < n; i++) begin
            checks++; if (got_a[i] !== model_q[i] || (i < got_b.size() && got_b[i] !== model_q[i])) begin
               errors++; $display("FAIL rnd%0d_word%0d: a=%h b=%h want %h", it, i, got_a[i],
                                  (i < got_b.size()) ? got_b[i] : 16'h0, model_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_record();
      test_play();
      test_backpressure();
      test_overflow();
      test_abort();
      test_boundary();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
